neuron_mac_seq: RTL and testbench

Time-multiplexed, parametrised successor to the layer-2 neuron: computes one ReLU/saturating neuron output `out = act(sum_i feature_i * weight_i + bias)` over HIDDEN inputs, consuming LANES products per clock instead of all products in a single cycle. It sits between the layer-1 output register bank and the class-score / argmax stage. It adds a start/busy/done handshake, a signed multi-bit bias, selectable activation, and explicit saturation.

---
 rtl/neuron_mac_seq.sv | 146 ++++++++++++++
 tb/tb_neuron_mac_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - time-multiplexed MAC neuron, LANES products per clock
// Captures operands on start, accumulates G=HIDDEN/LANES groups, then biases and saturates.
module neuron_mac_seq #(
  parameter int HIDDEN   = 100,
  parameter int LANES    = 4,
  parameter int IN_BIT   = 4,
  parameter int W_BIT    = 4,
  parameter int BIAS_BIT = 8,
  parameter int ACC_BIT  = 16,
  parameter int OUT_BIT  = 8
) (
  input  logic                       clk3,
  input  logic                       reset1,
  input  logic                       start,
  input  logic                       relu_en,
  input  logic [BIAS_BIT-1:0]        bias,
  input  logic [IN_BIT*HIDDEN-1:0]   input_features,
  input  logic [W_BIT*HIDDEN-1:0]    input_weights,
  output logic                       busy,
  output logic                       done,
  output logic [OUT_BIT-1:0]         out
);

  localparam int G  = HIDDEN / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int PW = IN_BIT + W_BIT + 1;
  localparam int SW = ACC_BIT + 1;

  localparam logic signed [SW-1:0] ZERO  = '0;
  localparam logic signed [SW-1:0] U_MAX = SW'((1 << OUT_BIT) - 1);
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (OUT_BIT - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_t;

  state_t                      state_q, state_d;
  logic [IN_BIT*HIDDEN-1:0]    feat_q, feat_d;
  logic [W_BIT*HIDDEN-1:0]     weight_q, weight_d;
  logic [BIAS_BIT-1:0]         bias_q, bias_d;
  logic                        relu_q, relu_d;
  logic signed [ACC_BIT-1:0]   acc_q, acc_d;
  logic [GW-1:0]               g_q, g_d;
  logic                        done_q, done_d;
  logic [OUT_BIT-1:0]          out_q, out_d;

  logic signed [ACC_BIT-1:0]   group_sum;
  logic signed [SW-1:0]        s;
  logic [OUT_BIT-1:0]          act;

  function automatic logic signed [ACC_BIT-1:0] lane_prod(
    input logic [IN_BIT-1:0] f,
    input logic [W_BIT-1:0]  w
  );
    logic signed [PW-1:0] p;
    p = $signed({1'b0, f}) * $signed(w);
    return {{(ACC_BIT-PW){p[PW-1]}}, p};
  endfunction

  // Operand registers shift down one group per ACC edge, so lanes always read the low slice.
  always_comb begin
    group_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      group_sum = group_sum + lane_prod(feat_q[l*IN_BIT +: IN_BIT], weight_q[l*W_BIT +: W_BIT]);
    end
  end

  always_comb begin
    s = {acc_q[ACC_BIT-1], acc_q} + {{(SW-BIAS_BIT){bias_q[BIAS_BIT-1]}}, bias_q};
    if (relu_q) begin
      if (s <= ZERO)       act = '0;
      else if (s >= U_MAX) act = '1;
      else                 act = s[OUT_BIT-1:0];
    end else begin
      if (s > S_MAX)       act = S_MAX[OUT_BIT-1:0];
      else if (s < S_MIN)  act = S_MIN[OUT_BIT-1:0];
      else                 act = s[OUT_BIT-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    g_d      = g_q;
    done_d   = 1'b0;
    out_d    = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          feat_d   = input_features;
          weight_d = input_weights;
          bias_d   = bias;
          relu_d   = relu_en;
          acc_d    = '0;
          g_d      = '0;
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        acc_d    = acc_q + group_sum;
        feat_d   = feat_q >> (LANES * IN_BIT);
        weight_d = weight_q >> (LANES * W_BIT);
        g_d      = g_q + GW'(1);
        if (g_q == GW'(G - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        out_d   = act;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk3 or posedge reset1) begin
    if (reset1) begin
      state_q  <= S_IDLE;
      feat_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      g_q      <= '0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      g_q      <= g_d;
      done_q   <= done_d;
      out_q    <= out_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb/tb_neuron_mac_seq.sv - directed self-checking bench for neuron_mac_seq
// Default instance plus a LANES=1, HIDDEN=10 variant sharing clock and reset.
module tb_neuron_mac_seq;

  logic         clk3 = 1'b0;
  logic         reset1;
  logic         start, relu_en;
  logic [7:0]   bias;
  logic [399:0] input_features, input_weights;
  logic         busy, done;
  logic [7:0]   out;

  logic         start2, relu2;
  logic [7:0]   bias2;
  logic [39:0]  feat2, wt2;
  logic         busy2, done2;
  logic [7:0]   out2;

  logic [399:0] f15, f3, fz, w7, w8, w2;
  int n_pass = 0;
  int n_total = 0;
  int lat, gaps;

  always #5 clk3 = ~clk3;

  neuron_mac_seq dut (
    .clk3(clk3), .reset1(reset1), .start(start), .relu_en(relu_en), .bias(bias),
    .input_features(input_features), .input_weights(input_weights),
    .busy(busy), .done(done), .out(out)
  );

  neuron_mac_seq #(.HIDDEN(10), .LANES(1)) dut2 (
    .clk3(clk3), .reset1(reset1), .start(start2), .relu_en(relu2), .bias(bias2),
    .input_features(feat2), .input_weights(wt2),
    .busy(busy2), .done(done2), .out(out2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  task automatic launch(input logic [399:0] f, input logic [399:0] w,
                        input logic [7:0] b, input logic r);
    input_features = f;
    input_weights  = w;
    bias           = b;
    relu_en        = r;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  task automatic wait_done(output int l, output int g);
    l = 0;
    g = 0;
    do begin
      tick();
      l++;
      if (!done && !busy) g++;
    end while (!done && l < 100);
  endtask

  initial begin
    f15 = {100{4'hF}};
    fz  = '0;
    f3  = '0;  f3[3:0] = 4'd3;
    w7  = {100{4'h7}};
    w8  = {100{4'h8}};
    w2  = '0;  w2[3:0] = 4'd2;
    reset1 = 1'b1;
    start = 1'b0; relu_en = 1'b0; bias = '0;
    input_features = '0; input_weights = '0;
    start2 = 1'b0; relu2 = 1'b1; bias2 = '0; wt2 = {10{4'h1}};
    for (int i = 0; i < 10; i++) feat2[4*i +: 4] = 4'(i + 1);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", out, 0);
    check("reset_out2", out2, 0);
    @(negedge clk3);
    reset1 = 1'b0;

    launch(f15, w7, 8'h00, 1'b1);
    check("t1_busy_after_start", busy, 1);
    wait_done(lat, gaps);
    check("t1_latency", lat, 26);
    check("t1_busy_gaps", gaps, 0);
    check("t1_out", out, 8'hFF);
    check("t1_busy_low_at_done", busy, 0);
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_out_held", out, 8'hFF);

    launch(f15, w7, 8'h00, 1'b0);
    wait_done(lat, gaps);
    check("t1s_out", out, 8'h7F);

    launch(f15, w8, 8'h00, 1'b1);
    wait_done(lat, gaps);
    check("t2_relu_out", out, 8'h00);
    launch(f15, w8, 8'h00, 1'b0);
    wait_done(lat, gaps);
    check("t2_signed_out", out, 8'h80);

    launch(f3, w2, 8'hFF, 1'b1);
    wait_done(lat, gaps);
    check("t3_out_bias_m1", out, 5);
    launch(f3, w2, 8'hF0, 1'b1);
    wait_done(lat, gaps);
    check("t3_out_bias_m16", out, 0);
    launch(f3, w2, 8'hF0, 1'b0);
    wait_done(lat, gaps);
    check("t3_signed_m10", out, 8'hF6);

    launch(f15, w7, 8'h00, 1'b1);
    lat = 1;
    tick();
    input_features = fz;
    input_weights  = w8;
    bias           = 8'h80;
    relu_en        = 1'b0;
    while (!done && lat < 100) begin
      start = (lat == 10);
      tick();
      lat++;
    end
    start = 1'b0;
    check("t4_latency", lat, 26);
    check("t4_captured_out", out, 8'hFF);
    launch(f3, w2, 8'hFF, 1'b1);
    check("t4_done_dropped", done, 0);
    check("t4_b2b_busy", busy, 1);
    wait_done(lat, gaps);
    check("t4_b2b_latency", lat, 26);
    check("t4_b2b_out", out, 5);

    launch(f15, w7, 8'h00, 1'b1);
    repeat (10) tick();
    #2;
    reset1 = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_out", out, 0);
    #1;
    reset1 = 1'b0;
    launch(f15, w7, 8'h00, 1'b1);
    wait_done(lat, gaps);
    check("t5_latency", lat, 26);
    check("t5_out", out, 8'hFF);

    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done2 && lat < 100);
    check("t6_latency", lat, 11);
    check("t6_out", out2, 55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
